message_loader: RTL and testbench
=================================

# message_loader

Upstream feeder for the memory-encrypt controller. It accepts a plaintext message byte-by-byte over a valid/ready handshake and writes it into the 16-entry, 8-bit message memory starting at address 0. It zero-terminates the message when it is shorter than 16 bytes, pulses `encrypt_start` to launch the encrypt pass, then waits for `encrypt_done` before signalling completion.

## Interface
- No parameters. The memory depth of 16 and the byte width of 8 are fixed by the message memory.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  message byte.
- `in_last`  in  1  qualifies `in_data` as the final byte of the message.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  4  memory write address.
- `mem_wdata`  out  8  memory write data.
- `encrypt_start`  out  1  one-cycle pulse that launches the encrypt controller.
- `encrypt_done`  in  1  encrypt controller has reached its end state (level).
- `load_done`  out  1  message loaded and encrypted; held high until `restart`.
- `msg_len`  out  5  count of payload bytes written, excluding the terminator (0..16).
- `restart`  in  1  return to loading a new message; honoured only in DONE.

## Operation
- States: RESET, LOAD, TERM, FILL (macro only), START, WAIT, DONE.
- Internal counter `count`, 5 bits, unsigned.
  - Cleared on `reset`.
  - Cleared on RESET→LOAD and on DONE→LOAD.
- RESET:
  - All outputs are 0 and `count` = 0.
  - Next state is LOAD unconditionally.
- LOAD:
  - `in_ready` = 1.
  - A transfer occurs when `in_valid` & `in_ready`. On a transfer: `mem_we` = 1, `mem_addr` = `count[3:0]`, `mem_wdata` = `in_data`.
  - A transfer with `in_data` == 0 writes the zero as the terminator and goes to START. `count` is unchanged, so the zero is not counted in `msg_len`.
  - Otherwise a transfer increments `count`.
  - If the new `count` == 16, go to START. No terminator is written; the encrypt controller stops at index 16.
  - Otherwise, if `in_last` = 1, go to TERM.
  - Otherwise, stay in LOAD.
- TERM:
  - `mem_we` = 1, `mem_addr` = `count[3:0]`, `mem_wdata` = 0.
  - Next state is FILL when the macro is defined and `count` < 15; otherwise START.
- START:
  - `encrypt_start` = 1 for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - Go to DONE when `encrypt_done` = 1; otherwise stay.
- DONE:
  - `load_done` = 1.
  - `restart` = 1 takes the state machine to LOAD.
- `msg_len` = `count` in every state.
- `in_ready` is 0 in every state other than LOAD.
- `restart` outside DONE is ignored.
- `in_last` accompanying a zero byte is ignored; the zero already terminates the message.
- Reset mid-operation, including during TERM, FILL, or WAIT: the next state is RESET. Partial memory contents are left as written, and no further writes or pulses occur.

## Timing
- All outputs are decoded from the current state (plus the handshake in LOAD); none are registered.
- Memory write latency: a byte accepted at rising edge k is written at edge k, with `mem_we`/`mem_addr`/`mem_wdata` valid in the cycle ending at k.
- Throughput in LOAD: one byte per cycle.
- Latencies after the last byte accepted at edge k:
  - Terminated message: TERM occupies cycle k..k+1, and `encrypt_start` is high in the cycle ending at edge k+2.
  - Full 16-byte message: `encrypt_start` is high in the cycle ending at edge k+1.
- `load_done` rises on the first cycle after WAIT samples `encrypt_done` = 1.
- After `reset` deasserts, `in_ready` first rises two edges later (RESET→LOAD).

## Configuration
- `MESSAGE_LOADER_ZERO_FILL_EN` defined:
  - After TERM, FILL writes 0 to addresses `count`+1 through 15, one per cycle, with `mem_we` = 1 and `mem_wdata` = 0.
  - Then START. `encrypt_start` is delayed by (15 − `count`) cycles.
  - Stale bytes from a previous message are therefore cleared.
- Macro undefined:
  - The FILL state is absent and TERM goes straight to START.
  - Addresses beyond the terminator keep their old contents.

## Test plan
- Reset, then stream "HI" (0x48, 0x49 with `in_last`) → writes mem[0] = 0x48, mem[1] = 0x49, mem[2] = 0x00; one-cycle `encrypt_start`; `msg_len` = 2.
- Stream 16 nonzero bytes 0x01..0x10 with `in_valid` held high → 16 consecutive writes to addresses 0..15; no terminator write; `encrypt_start` at edge k+1; `msg_len` = 16; `in_ready` low afterwards.
- Stream 0x41, 0x00, 0x42 → 0x00 written at address 1; `in_ready` drops and 0x42 is never accepted; `msg_len` = 1.
- Toggle `in_valid` every other cycle while holding `encrypt_done` low for 10 cycles → writes only on handshake cycles; state remains WAIT; `load_done` stays 0 until `encrypt_done` = 1, then `load_done` = 1; `restart` → `in_ready` = 1 and `msg_len` = 0.
- Assert `reset` during WAIT, then `restart` during LOAD → no `encrypt_start`; outputs are 0 in the RESET cycle; `restart` has no effect in LOAD.
- `MESSAGE_LOADER_ZERO_FILL_EN` defined, message of 3 bytes → terminator at address 3, then zero writes at addresses 4..15; `encrypt_start` 12 cycles later than in the macro-undefined build.

Source files
------------

// File: rtl/message_loader.sv
// message_loader: byte-stream front end for the memory-encrypt controller.
// Accepts a message over valid/ready, writes it into the 16x8 message memory
// from address 0, zero-terminates short messages, launches the encrypt pass
// with a one-cycle encrypt_start and reports load_done once it finishes.
//
// Optional build macro: MESSAGE_LOADER_ZERO_FILL_EN
//   When defined, addresses past the terminator are cleared to zero (FILL
//   state) before the encrypt pass starts, so no stale bytes survive.

module message_loader (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       encrypt_start,
    input  logic       encrypt_done,
    output logic       load_done,
    output logic [4:0] msg_len,
    input  logic       restart
);

    typedef enum logic [2:0] {
        S_RESET,
        S_LOAD,
        S_TERM,
        S_START,
        S_WAIT,
        S_DONE
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
        , S_FILL
`endif
    } state_t;

    state_t     state;
    logic [4:0] count;   // payload bytes accepted, terminator excluded
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
    logic [3:0] fill_addr;
`endif

    // State and byte counter; reset wins over everything and leaves memory as-is
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RESET;
            count <= 5'd0;
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
            fill_addr <= 4'd0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    count <= 5'd0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (in_data == 8'd0) begin
                            // zero byte is itself the terminator; in_last is moot
                            state <= S_START;
                        end else begin
                            count <= count + 5'd1;
                            if (count == 5'd15)
                                state <= S_START;   // full memory, no terminator
                            else if (in_last)
                                state <= S_TERM;
                        end
                    end
                end
                S_TERM: begin
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
                    if (count < 5'd15) begin
                        fill_addr <= count[3:0] + 4'd1;
                        state     <= S_FILL;
                    end else begin
                        state <= S_START;
                    end
`else
                    state <= S_START;
`endif
                end
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
                S_FILL: begin
                    if (fill_addr == 4'd15)
                        state <= S_START;
                    else
                        fill_addr <= fill_addr + 4'd1;
                end
`endif
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (encrypt_done)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (restart) begin
                        count <= 5'd0;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    // Outputs decoded from state (plus the handshake while loading)
    always_comb begin
        in_ready      = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 4'd0;
        mem_wdata     = 8'd0;
        encrypt_start = 1'b0;
        load_done     = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addr  = count[3:0];
                mem_wdata = in_data;
            end
            S_TERM: begin
                mem_we   = 1'b1;
                mem_addr = count[3:0];
            end
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
            S_FILL: begin
                mem_we   = 1'b1;
                mem_addr = fill_addr;
            end
`endif
            S_START: encrypt_start = 1'b1;
            S_DONE:  load_done     = 1'b1;
            default: ;
        endcase
    end

    assign msg_len = count;

endmodule

// File: tb/tb_message_loader.sv
// Randomized bench for message_loader. A message-level reference model
// predicts memory contents, write count, msg_len and start latency.
module tb_message_loader;

    typedef logic [7:0] bq_t[$];

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       encrypt_start;
    logic       encrypt_done;
    logic       load_done;
    logic [4:0] msg_len;
    logic       restart;

    message_loader dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .encrypt_start(encrypt_start), .encrypt_done(encrypt_done),
        .load_done(load_done), .msg_len(msg_len), .restart(restart)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: captured memory image, write/start counters, timestamps
    int         cyc = 0;
    logic [7:0] obs_mem [16];
    int         wr_cnt = 0;
    int         start_cnt = 0;
    int         acc_cyc = 0;
    int         start_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_we) begin
            obs_mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (in_valid && in_ready) acc_cyc <= cyc;
        if (encrypt_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    // Reference memory image, starts unknown like the real memory
    logic [7:0] mdl_mem [16];

    // Message-level model: what ends up in memory and how long until start
    function automatic void model_msg(input bq_t msg, input bit use_last,
                                      output int len, output int lat, output int nwr);
        len = 0; lat = 0; nwr = 0;
        for (int i = 0; i < msg.size(); i++) begin
            if (msg[i] == 8'd0) begin
                mdl_mem[len] = 8'd0;
                nwr = len + 1;
                lat = 1;
                return;
            end
            mdl_mem[len] = msg[i];
            len++;
            if (len == 16) begin
                nwr = 16;
                lat = 1;
                return;
            end
            if (use_last && i == msg.size() - 1) begin
                mdl_mem[len] = 8'd0;
                nwr = len + 1;
                lat = 2;
`ifdef MESSAGE_LOADER_ZERO_FILL_EN
                for (int a = len + 1; a < 16; a++) mdl_mem[a] = 8'd0;
                nwr += 15 - len;
                lat += 15 - len;
`endif
                return;
            end
        end
    endfunction

    task automatic drive_bytes(input bq_t msg, input bit use_last, input int max_gap);
        int n = 0;
        while (!in_ready && n < 20) begin @(posedge clock); #1; n++; end
        chk("ready_before_msg", in_ready, 1);
        for (int i = 0; i < msg.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = use_last && (i == msg.size() - 1);
            @(negedge clock);
            if (!in_ready) break;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic wait_start(input int s0);
        int n = 0;
        while (start_cnt == s0 && n < 40) begin @(posedge clock); #1; n++; end
        chk("start_seen", (start_cnt != s0), 1);
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic run_msg(input bq_t msg, input bit use_last, input int max_gap);
        int len, lat, nwr, w0, s0;
        model_msg(msg, use_last, len, lat, nwr);
        @(posedge clock); #1;
        w0 = wr_cnt;
        s0 = start_cnt;
        drive_bytes(msg, use_last, max_gap);
        wait_start(s0);
        chk("start_pulses", start_cnt - s0, 1);
        chk("start_latency", start_cyc - acc_cyc, lat);
        chk("write_count", wr_cnt - w0, nwr);
        chk("msg_len", msg_len, len);
        chk("ready_in_wait", in_ready, 0);
        repeat ($urandom_range(1, 10)) begin @(posedge clock); #1; end
        chk("load_done_while_busy", load_done, 0);
        encrypt_done = 1'b1;
        @(posedge clock); #1;
        encrypt_done = 1'b0;
        chk("load_done", load_done, 1);
        chk("ready_in_done", in_ready, 0);
        chk("msg_len_done", msg_len, len);
        for (int a = 0; a < 16; a++)
            chk($sformatf("mem[%0d]", a), obs_mem[a], mdl_mem[a]);
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        chk("ready_after_restart", in_ready, 1);
        chk("msg_len_after_restart", msg_len, 0);
        chk("load_done_after_restart", load_done, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_start"}, encrypt_start, 0);
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_msg_len"}, msg_len, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t msg;
        int  kind, n, s0, len, lat, nwr;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
        encrypt_done = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_idle_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("ready_one_edge_after_reset", in_ready, 0);
        @(posedge clock); #1;
        chk("ready_two_edges_after_reset", in_ready, 1);

        // "HI" terminated message
        msg = '{8'h48, 8'h49};
        run_msg(msg, 1'b1, 0);

        // full 16-byte message, valid held high, extra byte refused
        msg = {};
        for (int i = 1; i <= 17; i++) msg.push_back(8'(i));
        run_msg(msg, 1'b0, 0);

        // zero in mid-stream terminates; trailing byte never accepted
        msg = '{8'h41, 8'h00, 8'h42};
        run_msg(msg, 1'b1, 0);

        // empty message: first byte is the terminator
        msg = '{8'h00};
        run_msg(msg, 1'b0, 1);

        // 3-byte message, valid toggling every other cycle
        msg = '{8'h11, 8'h22, 8'h33};
        run_msg(msg, 1'b1, 1);

        // reset during WAIT, then restart in LOAD does nothing
        msg = '{8'h5a, 8'ha5};
        model_msg(msg, 1'b1, len, lat, nwr);
        @(posedge clock); #1;
        s0 = start_cnt;
        drive_bytes(msg, 1'b1, 0);
        wait_start(s0);
        encrypt_done = 1'b1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        s0 = start_cnt;
        @(negedge clock);
        chk_idle_outputs("reset_in_wait");
        @(posedge clock); #1;
        encrypt_done = 1'b0;
        chk("ready_after_wait_reset", in_ready, 1);
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        chk("restart_in_load_ready", in_ready, 1);
        chk("restart_in_load_len", msg_len, 0);
        chk("restart_in_load_done", load_done, 0);
        chk("no_start_after_reset", start_cnt - s0, 0);
        for (int a = 0; a < 4; a++)
            chk($sformatf("mem_after_reset[%0d]", a), obs_mem[a], mdl_mem[a]);

        // randomized messages of all three termination kinds
        for (int t = 0; t < 20; t++) begin
            msg  = {};
            kind = $urandom_range(0, 2);
            case (kind)
                0: begin
                    n = $urandom_range(1, 16);
                    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(1, 255)));
                end
                1: begin
                    n = $urandom_range(0, 10);
                    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(1, 255)));
                    msg.push_back(8'h00);
                    msg.push_back(8'($urandom_range(1, 255)));
                end
                default: begin
                    for (int i = 0; i < 18; i++) msg.push_back(8'($urandom_range(1, 255)));
                end
            endcase
            run_msg(msg, (kind != 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
